// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and the
// default ACCESS-phase timeout (also used by the UART/GPIO APB slave benches).
package apb_pkg;

    localparam int APB_ADDR_W  = 32;
    localparam int APB_DATA_W  = 32;
    localparam int APB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter.
//   PCLK, PRESETn : clock, async active-low reset
//   clear         : zero the count (asserted on the edge that enters ACCESS)
//   enable        : one ACCESS cycle elapsed with PREADY low
//   expired       : this edge brings the count to TIMEOUT (combinational)
// With TIMEOUT=0 the counter is removed and expired is tied to 0.
module apb_timeout_cnt #(
    parameter int TIMEOUT = apb_pkg::APB_TIMEOUT
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
            logic [CNT_W-1:0] cnt_q;

            // Abort is decided on the edge where the count would reach
            // TIMEOUT, so exactly TIMEOUT low-PREADY ACCESS cycles are seen.
            assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

            always_ff @(posedge PCLK or negedge PRESETn) begin
                if (!PRESETn) begin
                    cnt_q <= '0;
                end else if (clear) begin
                    cnt_q <= '0;
                end else if (enable && (cnt_q != CNT_W'(TIMEOUT))) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/apb_master.sv
// APB requester: turns single-word command handshakes into APB SETUP/ACCESS
// transfers, one outstanding at a time, with optional ACCESS timeout.
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata : command handshake
//   rsp_valid/rsp_rdata/rsp_timeout                 : one-cycle completion
//   busy                                            : transfer in progress
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PREADY/PRDATA  : APB requester port
// All bus and response outputs come straight from flops.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   ST_IDLE   | bus idle, command accepted when cmd_valid
//   ST_SETUP  | PSEL=1 PENABLE=0, one cycle, PREADY ignored
//   ST_ACCESS | PSEL=1 PENABLE=1, wait for PREADY or timeout
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA
);

    apb_state_e        state_q, state_d;
    logic              pwrite_d;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_d;
    logic              rsp_valid_d, rsp_timeout_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic              psel_d, penable_d;
    logic              expired;

    // Gating with PRESETn keeps cmd_ready low throughout reset.
    assign cmd_ready = (state_q == ST_IDLE) && PRESETn;

    apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clear   (state_q == ST_SETUP),
        .enable  ((state_q == ST_ACCESS) && !PREADY),
        .expired (expired)
    );

    always_comb begin
        state_d       = state_q;
        pwrite_d      = PWRITE;
        paddr_d       = PADDR;
        pwdata_d      = PWDATA;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_rdata_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // PREADY takes priority over a simultaneous timeout.
                if (PREADY) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = PWRITE ? '0 : PRDATA;
                end else if (expired) begin
                    state_d       = ST_IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        psel_d    = (state_d != ST_IDLE);
        penable_d = (state_d == ST_ACCESS);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            busy        <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            state_q     <= state_d;
            PSEL        <= psel_d;
            PENABLE     <= penable_d;
            busy        <= psel_d;
            PWRITE      <= pwrite_d;
            PADDR       <= paddr_d;
            PWDATA      <= pwdata_d;
            rsp_valid   <= rsp_valid_d;
            rsp_timeout <= rsp_timeout_d;
            rsp_rdata   <= rsp_rdata_d;
        end
    end

endmodule
